// File: rtl/program_loader.sv
// program_loader: boot-time copier from a synchronous instruction ROM into the
// CPU instruction-memory write port. One word costs two cycles: READ presents
// the ROM address, WRITE forwards the returned word to the CPU with a one-cycle
// write strobe. The CPU is held (cpu_run=0) until a load has completed.
//
// Handshake: there is no back-pressure. write is a single-cycle strobe and
// write_instruction_index/write_instruction are only meaningful while write=1.
// reload is a single-cycle request that is honoured only in IDLE or DONE.
module program_loader #(
  parameter int INSTR_WIDTH = 16,
  parameter int INDEX_WIDTH = 8,
  parameter int PROG_LEN    = 13,
  parameter int BASE_INDEX  = 10,
  parameter int AUTO_START  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reload,
  output logic [INDEX_WIDTH-1:0] rom_addr,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic                   write,
  output logic [INDEX_WIDTH-1:0] write_instruction_index,
  output logic [INSTR_WIDTH-1:0] write_instruction,
  output logic                   cpu_run,
  output logic                   busy,
  output logic                   done,
  output logic [INSTR_WIDTH-1:0] checksum
);

  // The program must fit inside the CPU instruction index space.
  if ((PROG_LEN < 0) || (PROG_LEN > (1 << INDEX_WIDTH)) ||
      (BASE_INDEX < 0) || (BASE_INDEX + PROG_LEN > (1 << INDEX_WIDTH))) begin : g_bad_params
    $error("program_loader: BASE_INDEX + PROG_LEN exceeds the instruction index space");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_K = INDEX_WIDTH'((PROG_LEN > 0) ? PROG_LEN - 1 : 0);
  localparam logic [INDEX_WIDTH-1:0] BASE   = INDEX_WIDTH'(BASE_INDEX);
  localparam logic [INDEX_WIDTH-1:0] ONE    = INDEX_WIDTH'(1);

  // An empty program completes instantly, so a start lands straight in DONE.
  localparam state_t START_STATE = (PROG_LEN > 0) ? READ : DONE;
  localparam state_t RESET_STATE = (AUTO_START == 0) ? IDLE : START_STATE;

  // state is kept as a named signal so checkers can observe the FSM directly.
  state_t                 state;
  state_t                 state_next;
  logic [INDEX_WIDTH-1:0] k;
  logic [INDEX_WIDTH-1:0] k_next;
  logic [INSTR_WIDTH-1:0] sum;
  logic [INSTR_WIDTH-1:0] sum_next;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [INDEX_WIDTH-1:0] idx_next;
  logic [INSTR_WIDTH-1:0] ins_q;
  logic [INSTR_WIDTH-1:0] ins_next;

  // State, word counter, checksum and last-written word/index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
      k     <= '0;
      sum   <= '0;
      idx_q <= '0;
      ins_q <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      sum   <= sum_next;
      idx_q <= idx_next;
      ins_q <= ins_next;
    end
  end

  // Next-state logic: start on reload from IDLE/DONE, alternate READ/WRITE per word.
  always_comb begin
    state_next = state;
    k_next     = k;
    sum_next   = sum;
    idx_next   = idx_q;
    ins_next   = ins_q;
    case (state)
      IDLE, DONE: begin
        if (reload) begin
          state_next = START_STATE;
          k_next     = '0;
          sum_next   = '0;
        end
      end
      READ: begin
        state_next = WRITE;
      end
      WRITE: begin
        idx_next = BASE + k;
        ins_next = rom_data;
        sum_next = sum + rom_data;
        if (k == LAST_K) begin
          state_next = DONE;
        end else begin
          k_next     = k + ONE;
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state. The reset state may be READ or DONE, so
  // busy/done/cpu_run are also qualified by rst_n to read as idle while reset
  // is held.
  always_comb begin
    rom_addr                = k;
    write                   = (state == WRITE);
    write_instruction_index = (state == WRITE) ? (BASE + k) : idx_q;
    write_instruction       = (state == WRITE) ? rom_data : ins_q;
    busy                    = rst_n & ((state == READ) || (state == WRITE));
    done                    = rst_n & (state == DONE);
    cpu_run                 = rst_n & (state == DONE);
    checksum                = sum;
  end

endmodule
